// File: rtl/qed_dup_scheduler.sv
// rtl/qed_dup_scheduler.sv - SQED issue scheduler: passes originals, queues them, drains register-remapped duplicates
module qed_dup_scheduler #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    input  logic                       qed_exec_dup,
    input  logic                       stall,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic                       out_is_dup,
    output logic [$clog2(DEPTH):0]     dup_count,
    output logic                       qed_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {ORIG, DUP} state_t;

    state_t          state, state_next;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count, count_next;
    logic            accept, start_dup, pop, nonempty, full;

    // Originals only touch x0-x15, so setting bit4 of a nonzero field maps it into x16-x31.
    function automatic logic [31:0] remap(input logic [31:0] i);
        logic [31:0] r;
        r = i;
        case (i[6:0])
            7'b0110011: begin
                r[11] = i[11] | (|i[11:7]);
                r[19] = i[19] | (|i[19:15]);
                r[24] = i[24] | (|i[24:20]);
            end
            7'b0010011, 7'b0000011: begin
                r[11] = i[11] | (|i[11:7]);
                r[19] = i[19] | (|i[19:15]);
            end
            7'b0100011, 7'b1100011: begin
                r[19] = i[19] | (|i[19:15]);
                r[24] = i[24] | (|i[24:20]);
            end
            default: r = NOP;
        endcase
        return r;
    endfunction

    assign nonempty  = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign in_ready  = (state == ORIG) && !stall && !full && !(qed_exec_dup && nonempty);
    assign accept    = in_valid && in_ready;
    assign start_dup = (state == ORIG) && qed_exec_dup && nonempty && !stall;
    assign pop       = (state == DUP) && !stall;
    assign dup_count = count;

    always_comb begin
        state_next = state;
        count_next = count;
        if (start_dup)
            state_next = DUP;
        if (accept)
            count_next = count + CW'(1);
        if (pop) begin
            count_next = count - CW'(1);
            if (count == CW'(1))
                state_next = ORIG;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[tail] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ORIG;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_instr  <= NOP;
            out_is_dup <= 1'b0;
            qed_done   <= 1'b1;
        end else begin
            state    <= state_next;
            count    <= count_next;
            qed_done <= (state_next == ORIG) && (count_next == '0);
            if (accept) begin
                tail       <= tail + AW'(1);
                out_valid  <= 1'b1;
                out_instr  <= in_instr;
                out_is_dup <= 1'b0;
            end else if (pop) begin
                head       <= head + AW'(1);
                out_valid  <= 1'b1;
                out_instr  <= remap(mem[head]);
                out_is_dup <= 1'b1;
            end else if (!stall) begin
                // Idle, full-queue and ORIG->DUP cycles all issue a bubble.
                out_valid  <= 1'b0;
                out_instr  <= NOP;
                out_is_dup <= 1'b0;
            end
        end
    end
endmodule
